mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port synchronous memory (registered read, one-cycle read latency, `me`/`we`/`oe` control) between `NUM_REQ` requesters. It uses round-robin arbitration with a valid/ready request handshake and a fixed-latency read response. The block sits between the requesting engines and the memory model, owns every memory control pin, and can accept one request per cycle.

## Interface
- `DATA_WIDTH`, 8, memory word width
- `ADDR_WIDTH`, 8, memory address width
- `NUM_REQ`, 2, number of requesters (2..8)
- `LOCK_MAX`, 16, maximum consecutive locked cycles (used only with lock feature)

- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester grant; one-hot or zero
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_lock`  in  NUM_REQ  request to hold grant (ignored without `MEM_ARB_LOCK_EN`)
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at slice i
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  flattened write data
- `rsp_valid`  out  NUM_REQ  read data valid, one-hot, to the originating requester
- `rsp_rdata`  out  DATA_WIDTH  read data, shared
- `mem_me`, `mem_we`, `mem_oe`  out  1 each  memory enable / write enable / output enable
- `mem_address`  out  ADDR_WIDTH  memory address
- `mem_data`  out  DATA_WIDTH  memory write data
- `mem_data_out`  in  DATA_WIDTH  memory read data

## Operation
- **Arbitration** is combinational in cycle T. The grant goes to the first valid requester at or after `rr_ptr`, searching upward and wrapping at `NUM_REQ`. `req_ready[i]` is asserted only for that requester. A request is accepted on `req_valid[i] && req_ready[i]`.
- **Round-robin pointer:** on accept, `rr_ptr` becomes the granted index + 1, modulo `NUM_REQ`. With no accept, `rr_ptr` holds.
- **Command stage** (registered):
  - On accept: `mem_me`=1, `mem_we`=`req_we`, `mem_oe`=!`req_we`, and address and data are copied from the granted slice.
  - With no accept: `mem_me`=`mem_we`=`mem_oe`=0. Address and data hold.
- **Read tracking:** a read accept loads a 2-deep shift of (valid, id). `rsp_valid[id]` is registered. `rsp_rdata` = `mem_data_out`, passed through.
- Writes produce no response.
- Responses cannot be back-pressured; requesters always accept them.
- **FSM** (`arb_state_t`):
  - `ARB`: normal arbitration as above.
  - `LOCKED`: only the stored `lock_owner` may be granted, whenever its `req_valid` is high. If the owner is idle, nothing is granted.
  - `ARB`→`LOCKED`: on an accepted beat with `req_lock`=1. `lock_owner` = granted index and `lock_cnt` = 0.
  - `LOCKED`→`ARB`: on an owner beat accepted with `req_lock`=0, or when `lock_cnt` reaches `LOCK_MAX`-1 (forced release).
  - On any exit, `rr_ptr` = owner + 1.
  - `lock_cnt` increments every cycle spent in `LOCKED`, whether or not a beat is accepted. The beat accepted in the release cycle is still issued.

## Timing
- **Read latency:** a read accepted in cycle T gives memory command in T+1, `mem_data_out` valid in T+2, and `rsp_valid` high in T+2 for exactly one cycle.
- **Write:** accepted in T, committed at the end of T+1. A read accepted in T+1 or later to the same address returns the new data.
- **Throughput:** one accept per cycle. Back-to-back reads give back-to-back responses.
- **Reset** (`rst_n`=0 sampled at an edge):
  - All outputs go to 0, `rr_ptr`=0, FSM=`ARB`, `lock_cnt`=0.
  - The response shift is cleared, so in-flight reads are dropped and no `rsp_valid` follows reset.
- **Simultaneous requests:** only one requester is granted. The others see `req_ready`=0 and must hold their request stable.

## Configuration
- `MEM_ARB_LOCK_EN` defined: lock FSM, `lock_owner`, `lock_cnt` and `LOCK_MAX` are compiled in.
- `MEM_ARB_LOCK_EN` undefined: `req_lock` is ignored, the FSM stays permanently in `ARB` and no lock registers exist. Pure round-robin.

## Structure
- In `DEFINE_PKG`: `arb_state_t` (`ARB`, `LOCKED`) and the `mem_cmd_t` struct (`me`, `we`, `oe`, address, data).
- One sub-module, `mem_rr_pick`: combinational rotate-priority picker. Inputs are the request vector and `rr_ptr`; outputs are a one-hot grant and the grant index.

## Test plan
- Reset with requests pending → all outputs 0 and no grant on the reset edge. The first grant after release goes to requester 0.
- Requester 0 and requester 1 both valid continuously, reads of 0x10 and 0x20 → grants alternate 0,1,0,1. `rsp_valid` arrives two cycles after each accept with the matching data.
- Requester 1 writes 0xA5 to 0x33 in T, requester 0 reads 0x33 in T+1 → `rsp_valid[0]` in T+3 with `rsp_rdata`=0xA5.
- With `MEM_ARB_LOCK_EN`: requester 1 issues locked beats while requester 0 is valid → requester 0 is starved until requester 1 sends a beat with `req_lock`=0. The next grant goes to requester 0.
- With `MEM_ARB_LOCK_EN` and `LOCK_MAX`=4: requester 0 holds `req_lock`=1 forever → forced release after 4 locked cycles and requester 1 is granted next.
- Read accepted, then `rst_n` low in T+1 → no `rsp_valid` ever appears for that read.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
// FSM states and the registered memory command bundle.
package mem_port_arbiter_pkg;

    localparam int CMD_AW = 8;
    localparam int CMD_DW = 8;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Command fields are sized by CMD_AW/CMD_DW; the top's
    // width parameters default to these values.
    typedef struct packed {
        logic              me;
        logic              we;
        logic              oe;
        logic [CMD_AW-1:0] addr;
        logic [CMD_DW-1:0] data;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or after
// i_ptr, wrapping at NUM_REQ. One-hot grant plus index.
module mem_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;

    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    // Scan the rotated vector from bit 0 and map the first hit back.
    always_comb begin
        int s;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        s       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any && w_rot[k]) begin
                o_any = 1'b1;
                s = int'(i_ptr) + k;
                if (s >= NUM_REQ) begin
                    s = s - NUM_REQ;
                end
                o_idx = IDX_W'(s);
            end
        end
        if (o_any) begin
            o_grant = NUM_REQ'(1) << o_idx;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port.
// Optional grant locking enabled by defining MEM_ARB_LOCK_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = CMD_DW,
    parameter int ADDR_WIDTH = CMD_AW,
    parameter int NUM_REQ    = 2,
    parameter int LOCK_MAX   = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [NUM_REQ-1:0]             i_req_we,
    input  logic [NUM_REQ-1:0]             i_req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_wdata,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    output logic [DATA_WIDTH-1:0]          o_rsp_rdata,
    output logic                           o_mem_me,
    output logic                           o_mem_we,
    output logic                           o_mem_oe,
    output logic [ADDR_WIDTH-1:0]          o_mem_address,
    output logic [DATA_WIDTH-1:0]          o_mem_data,
    input  logic [DATA_WIDTH-1:0]          i_mem_data_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]      r_rr_ptr;
    mem_cmd_t              r_cmd;
    logic                  r_rd_v;
    logic [IDX_W-1:0]      r_rd_id;
    logic [NUM_REQ-1:0]    r_rsp_valid;

    logic [NUM_REQ-1:0]    w_req_eff;
    logic [NUM_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_sel_we;
    logic                  w_sel_lock;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_release;
    logic [IDX_W-1:0]      w_owner;

    function automatic logic [IDX_W-1:0] f_next(
        input logic [IDX_W-1:0] idx
    );
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    mem_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (w_req_eff),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // No grant is visible while reset is being sampled.
    assign o_req_ready = i_rst_n ? w_grant : '0;
    assign w_accept    = i_rst_n && w_any;
    assign w_sel_we    = |(i_req_we & w_grant);
    assign w_sel_lock  = |(i_req_lock & w_grant);

    // Mux the granted requester's address and write data.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef MEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Lock FSM state, owner and locked-cycle counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ARB;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_cnt_nxt;
        end
    end

    // Lock entry on a locked beat; exit on unlocked beat or timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_lock_cnt;
        w_release   = 1'b0;
        unique case (r_state)
            ARB: begin
                if (w_accept && w_sel_lock) begin
                    w_state_nxt = LOCKED;
                    w_owner_nxt = w_idx;
                    w_cnt_nxt   = '0;
                end
            end
            LOCKED: begin
                w_cnt_nxt = r_lock_cnt + 1'b1;
                if ((w_accept && !w_sel_lock) ||
                    (r_lock_cnt == CNT_W'(LOCK_MAX - 1))) begin
                    w_state_nxt = ARB;
                    w_cnt_nxt   = '0;
                    w_release   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    assign w_owner   = r_owner;
    assign w_req_eff = (r_state == LOCKED)
                     ? (i_req_valid & (NUM_REQ'(1) << r_owner))
                     : i_req_valid;
`else
    logic w_unused_lock;

    assign w_unused_lock = ^{i_req_lock, w_sel_lock};
    assign w_release     = 1'b0;
    assign w_owner       = '0;
    assign w_req_eff     = i_req_valid;
`endif

    // Round-robin pointer: past the owner on release, else past winner.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_release) begin
            r_rr_ptr <= f_next(w_owner);
        end else if (w_accept) begin
            r_rr_ptr <= f_next(w_idx);
        end
    end

    // Command stage: pulse controls on accept, hold address and data.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cmd <= '0;
        end else if (w_accept) begin
            r_cmd.me   <= 1'b1;
            r_cmd.we   <= w_sel_we;
            r_cmd.oe   <= !w_sel_we;
            r_cmd.addr <= w_sel_addr;
            r_cmd.data <= w_sel_data;
        end else begin
            r_cmd.me <= 1'b0;
            r_cmd.we <= 1'b0;
            r_cmd.oe <= 1'b0;
        end
    end

    // Two-deep read tracker; second stage is the one-hot rsp_valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_v      <= 1'b0;
            r_rd_id     <= '0;
            r_rsp_valid <= '0;
        end else begin
            r_rd_v      <= w_accept && !w_sel_we;
            r_rd_id     <= w_idx;
            r_rsp_valid <= r_rd_v ? (NUM_REQ'(1) << r_rd_id) : '0;
        end
    end

    assign o_mem_me      = r_cmd.me;
    assign o_mem_we      = r_cmd.we;
    assign o_mem_oe      = r_cmd.oe;
    assign o_mem_address = r_cmd.addr;
    assign o_mem_data    = r_cmd.data;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = i_mem_data_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory.
// Lock steps are built only when MEM_ARB_LOCK_EN is defined.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  valid;
    logic [1:0]  ready;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  rsp_v;
    logic [7:0]  rdata;
    logic        me;
    logic        mwe;
    logic        moe;
    logic [7:0]  maddr;
    logic [7:0]  mdata;
    logic [7:0]  dout;

    logic [7:0]  mem [256];

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .NUM_REQ    (2),
        .LOCK_MAX   (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (valid),
        .o_req_ready    (ready),
        .i_req_we       (we),
        .i_req_lock     (lock),
        .i_req_addr     (addr),
        .i_req_wdata    (wdata),
        .o_rsp_valid    (rsp_v),
        .o_rsp_rdata    (rdata),
        .o_mem_me       (me),
        .o_mem_we       (mwe),
        .o_mem_oe       (moe),
        .o_mem_address  (maddr),
        .o_mem_data     (mdata),
        .i_mem_data_out (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
        end
    end

    always @(posedge clk) begin
        if (me && mwe) mem[maddr] <= mdata;
        if (me && moe) dout <= mem[maddr];
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 2'b11;
        we    = 2'b00;
        lock  = 2'b00;
        addr  = {8'h20, 8'h10};
        wdata = 16'h0000;
        nxt();
        nxt();
        smp();
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_me", 32'(me), 32'h0);
        chk("rst_rspv", 32'(rsp_v), 32'h0);
        chk("rst_addr", 32'(maddr), 32'h0);
        nxt();
        rst_n = 1'b1;
        smp();
        chk("g0", 32'(ready), 32'h1);
        nxt();
        smp();
        chk("g1", 32'(ready), 32'h2);
        chk("cmd_rd", 32'({me, mwe, moe}), 32'h5);
        chk("cmd_addr0", 32'(maddr), 32'h10);
        nxt();
        smp();
        chk("g2", 32'(ready), 32'h1);
        chk("rsp_a", 32'(rsp_v), 32'h1);
        chk("rdata_a", 32'(rdata), 32'h4A);
        chk("cmd_addr1", 32'(maddr), 32'h20);
        nxt();
        smp();
        chk("g3", 32'(ready), 32'h2);
        chk("rsp_b", 32'(rsp_v), 32'h2);
        chk("rdata_b", 32'(rdata), 32'h7A);
        nxt();
        valid = 2'b00;
        smp();
        chk("idle_ready", 32'(ready), 32'h0);
        chk("rsp_c", 32'(rsp_v), 32'h1);
        chk("rdata_c", 32'(rdata), 32'h4A);
        chk("me_tail", 32'(me), 32'h1);
        nxt();
        smp();
        chk("rsp_d", 32'(rsp_v), 32'h2);
        chk("rdata_d", 32'(rdata), 32'h7A);
        chk("me_idle", 32'(me), 32'h0);
        chk("addr_hold", 32'(maddr), 32'h20);
        nxt();
        smp();
        chk("rsp_none", 32'(rsp_v), 32'h0);

        // write 0xA5 to 0x33 from requester 1, then read back via 0
        nxt();
        valid = 2'b10;
        we    = 2'b10;
        addr  = {8'h33, 8'h10};
        wdata = {8'hA5, 8'h00};
        smp();
        chk("wr_grant", 32'(ready), 32'h2);
        nxt();
        valid = 2'b01;
        we    = 2'b00;
        addr  = {8'h33, 8'h33};
        smp();
        chk("rd_grant", 32'(ready), 32'h1);
        chk("wr_cmd", 32'({me, mwe, moe}), 32'h6);
        chk("wr_data", 32'(mdata), 32'hA5);
        chk("wr_addr", 32'(maddr), 32'h33);
        nxt();
        valid = 2'b00;
        smp();
        chk("wr_norsp", 32'(rsp_v), 32'h0);
        chk("rd_cmd", 32'({me, mwe, moe}), 32'h5);
        nxt();
        smp();
        chk("raw_rsp", 32'(rsp_v), 32'h1);
        chk("raw_data", 32'(rdata), 32'hA5);

        // read accepted, then reset in the following cycle
        nxt();
        valid = 2'b01;
        addr  = {8'h20, 8'h10};
        smp();
        chk("pre_rst_g", 32'(ready), 32'h1);
        nxt();
        rst_n = 1'b0;
        valid = 2'b11;
        smp();
        chk("rst_gate", 32'(ready), 32'h0);
        chk("rst_cmd", 32'(me), 32'h1);
        nxt();
        rst_n = 1'b1;
        valid = 2'b00;
        smp();
        chk("post_rst_me", 32'(me), 32'h0);
        chk("drop_rsp0", 32'(rsp_v), 32'h0);
        nxt();
        valid = 2'b11;
        smp();
        chk("drop_rsp1", 32'(rsp_v), 32'h0);
        chk("ptr_rst", 32'(ready), 32'h1);
        nxt();
`ifdef MEM_ARB_LOCK_EN
        lock = 2'b10;
        smp();
        chk("lk_enter", 32'(ready), 32'h2);
        nxt();
        valid = 2'b01;
        smp();
        chk("lk_idle", 32'(ready), 32'h0);
        nxt();
        valid = 2'b11;
        smp();
        chk("lk_hold", 32'(ready), 32'h2);
        nxt();
        lock = 2'b00;
        smp();
        chk("lk_last", 32'(ready), 32'h2);
        nxt();
        lock = 2'b01;
        smp();
        chk("lk_next", 32'(ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            nxt();
            smp();
            chk("lk_force", 32'(ready), 32'h1);
        end
        nxt();
        smp();
        chk("lk_free", 32'(ready), 32'h2);
`else
        lock = 2'b10;
        smp();
        chk("rr_a", 32'(ready), 32'h2);
        nxt();
        smp();
        chk("rr_b", 32'(ready), 32'h1);
        nxt();
        smp();
        chk("rr_c", 32'(ready), 32'h2);
`endif
        nxt();
        valid = 2'b00;
        lock  = 2'b00;
        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
